tdm_demux_1_8: RTL and testbench

//  Receive end of the 8:1 channel-select path: takes a time-multiplexed sample stream
//  (one channel per valid cycle, channel 0 flagged by frame_sync) and distributes it to
//  8 registered channel outputs plus a double-buffered full-frame output.

---
 rtl/tdm_demux_pkg.sv | 24 ++
 rtl/tdm_demux_1_8_if.sv | 23 ++
 rtl/tdm_demux_1_8_dec.sv | 18 +
 rtl/tdm_demux_1_8.sv | 157 +++++++++++++++
 tb/tb_tdm_demux_1_8.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 1:8 TDM demux.
// Lane n of every 8-lane bus occupies bits [n*W +: W].
package tdm_demux_pkg;

   localparam int NCH       = 8;
   localparam int SELW      = 3;
   localparam int LAST_LANE = NCH - 1;
   localparam int ERR_CNT_W = 8;

   localparam logic [SELW-1:0]      LANE_FIRST  = '0;
   localparam logic [SELW-1:0]      LANE_SECOND = SELW'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Low bit index of lane n in a packed bus of w-bit lanes.
   function automatic int lane_lo(input int n, input int w);
      return n * w;
   endfunction

endpackage

// File: rtl/tdm_demux_1_8_if.sv
// Time-multiplexed sample stream into the demux: one sample per valid cycle,
// frame_sync marks channel 0 and is only meaningful while din_valid is high.
interface tdm_demux_1_8_if #(
   parameter int W = 1
);

   logic [W-1:0] din;
   logic         din_valid;
   logic         frame_sync;

   modport master (
      output din,
      output din_valid,
      output frame_sync
   );

   modport slave (
      input din,
      input din_valid,
      input frame_sync
   );

endinterface

// File: rtl/tdm_demux_1_8_dec.sv
// 3-to-8 lane decoder: one-hot enable for the selected lane when en is high.
// Purely combinational; used for both lane loads and ch_stb.
module dec_3_8
   import tdm_demux_pkg::*;
(
   input  logic [SELW-1:0] sel,
   input  logic            en,
   output logic [NCH-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/tdm_demux_1_8.sv
// 1:8 TDM demux with frame alignment; every output registered 1 cycle after accept, no backpressure.
// Optional saturating sync-error counter on err_cnt when TDM_DEMUX_ERR_CNT_EN is defined.
module tdm_demux_1_8
   import tdm_demux_pkg::*;
#(
   parameter int W = 1
) (
   input  logic              clk,
   input  logic              rst,
   tdm_demux_1_8_if.slave    rx,
   output logic [SELW-1:0]   ch_sel,
   output logic [NCH*W-1:0]  ch_out,
   output logic [NCH-1:0]    ch_stb,
   output logic [NCH*W-1:0]  frame_out,
   output logic              frame_valid,
   output logic              locked,
   output logic              sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   state_t             state_q, state_d;
   logic [SELW-1:0]    cnt_q, cnt_d;
   logic [NCH*W-1:0]   ch_out_q, ch_out_d;
   logic [NCH*W-1:0]   shadow_q, shadow_d;
   logic [NCH*W-1:0]   frame_out_q, frame_out_d;
   logic [NCH-1:0]     ch_stb_q, ch_stb_d;
   logic               frame_valid_q, frame_valid_d;
   logic               locked_q, locked_d;
   logic               sync_err_q, sync_err_d;
   logic               wr_en;
   logic [SELW-1:0]    wr_lane;
   logic [NCH-1:0]     lane_en;

   // Alignment FSM: decides whether this accept writes a lane and which one.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_en      = 1'b0;
      wr_lane    = cnt_q;
      sync_err_d = 1'b0;
      if (rx.din_valid) begin
         unique case (state_q)
            ST_HUNT: begin
               if (rx.frame_sync) begin
                  wr_en   = 1'b1;
                  wr_lane = LANE_FIRST;
                  cnt_d   = LANE_SECOND;
                  state_d = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (rx.frame_sync == (cnt_q == LANE_FIRST)) begin
                  wr_en   = 1'b1;
                  wr_lane = cnt_q;
                  cnt_d   = cnt_q + 1'b1;
               end else if (rx.frame_sync) begin
                  // Early sync: abandon the partial frame and realign on this sample.
                  sync_err_d = 1'b1;
                  wr_en      = 1'b1;
                  wr_lane    = LANE_FIRST;
                  cnt_d      = LANE_SECOND;
               end else begin
                  sync_err_d = 1'b1;
                  cnt_d      = LANE_FIRST;
                  state_d    = ST_HUNT;
               end
            end
            default: begin
               cnt_d   = LANE_FIRST;
               state_d = ST_HUNT;
            end
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
   end

   dec_3_8 u_dec (
      .sel    (wr_lane),
      .en     (wr_en),
      .onehot (lane_en)
   );

   // Shadow collects the frame in progress; frame_out only ever takes a whole frame.
   always_comb begin
      ch_out_d    = ch_out_q;
      shadow_d    = shadow_q;
      frame_out_d = frame_out_q;
      ch_stb_d    = lane_en;
      for (int n = 0; n < NCH; n++) begin
         if (lane_en[n]) begin
            ch_out_d[lane_lo(n, W) +: W] = rx.din;
            shadow_d[lane_lo(n, W) +: W] = rx.din;
         end
      end
      frame_valid_d = lane_en[LAST_LANE];
      if (frame_valid_d) begin
         frame_out_d = shadow_d;
      end
   end

`ifdef TDM_DEMUX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (sync_err_d && (err_cnt_q != ERR_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_HUNT;
         cnt_q         <= '0;
         ch_out_q      <= '0;
         shadow_q      <= '0;
         frame_out_q   <= '0;
         ch_stb_q      <= '0;
         frame_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ch_out_q      <= ch_out_d;
         shadow_q      <= shadow_d;
         frame_out_q   <= frame_out_d;
         ch_stb_q      <= ch_stb_d;
         frame_valid_q <= frame_valid_d;
         locked_q      <= locked_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign ch_sel      = cnt_q;
   assign ch_out      = ch_out_q;
   assign ch_stb      = ch_stb_q;
   assign frame_out   = frame_out_q;
   assign frame_valid = frame_valid_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Directed bench for tdm_demux_1_8 (W=1); err_cnt checks only with TDM_DEMUX_ERR_CNT_EN.
module tb_tdm_demux_1_8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tdm_demux_1_8_if #(.W(1)) rx_if ();

   logic [2:0] ch_sel;
   logic [7:0] ch_out;
   logic [7:0] ch_stb;
   logic [7:0] frame_out;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   tdm_demux_1_8 #(.W(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx_if),
      .ch_sel      (ch_sel),
      .ch_out      (ch_out),
      .ch_stb      (ch_stb),
      .frame_out   (frame_out),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
      ,
      .err_cnt     (err_cnt)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_ch;
   logic [7:0] exp_frame;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic cycle(input logic v, input logic fs, input logic d);
      rx_if.din_valid  = v;
      rx_if.frame_sync = fs;
      rx_if.din        = d;
      @(posedge clk);
      #1;
   endtask

   task automatic lane(input logic fs, input logic d, input int idx, input logic exp_err);
      cycle(1'b1, fs, d);
      exp_ch[idx] = d;
      if (idx == 7) exp_frame = exp_ch;
      check("ch_stb",      32'(ch_stb),      32'(1 << idx));
      check("ch_sel",      32'(ch_sel),      32'((idx + 1) % 8));
      check("sync_err",    32'(sync_err),    32'(exp_err));
      check("locked",      32'(locked),      32'd1);
      check("frame_valid", 32'(frame_valid), 32'(idx == 7));
      check("ch_out",      32'(ch_out),      32'(exp_ch));
      check("frame_out",   32'(frame_out),   32'(exp_frame));
   endtask

   task automatic send_frame(input logic [7:0] pat, input logic err_first, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         lane(i == 0, pat[i], i, (i == 0) ? err_first : 1'b0);
         if (gaps) begin
            cycle(1'b0, 1'b1, ~pat[i]);
            check("gap_stb",    32'(ch_stb),      32'd0);
            check("gap_fv",     32'(frame_valid), 32'd0);
            check("gap_err",    32'(sync_err),    32'd0);
            check("gap_sel",    32'(ch_sel),      32'((i + 1) % 8));
            check("gap_ch_out", 32'(ch_out),      32'(exp_ch));
            check("gap_frame",  32'(frame_out),   32'(exp_frame));
         end
      end
      check("frame_pat", 32'(frame_out), 32'(pat));
   endtask

   task automatic drop(input logic d, input logic exp_err);
      cycle(1'b1, 1'b0, d);
      check("drop_stb",   32'(ch_stb),      32'd0);
      check("drop_err",   32'(sync_err),    32'(exp_err));
      check("drop_lock",  32'(locked),      32'd0);
      check("drop_sel",   32'(ch_sel),      32'd0);
      check("drop_fv",    32'(frame_valid), 32'd0);
      check("drop_chout", 32'(ch_out),      32'(exp_ch));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ch_out"},    32'(ch_out),      32'd0);
      check({tag, "_frame_out"}, 32'(frame_out),   32'd0);
      check({tag, "_ch_stb"},    32'(ch_stb),      32'd0);
      check({tag, "_ch_sel"},    32'(ch_sel),      32'd0);
      check({tag, "_fv"},        32'(frame_valid), 32'd0);
      check({tag, "_locked"},    32'(locked),      32'd0);
      check({tag, "_sync_err"},  32'(sync_err),    32'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
      check({tag, "_err_cnt"},   32'(err_cnt),     32'd0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      exp_ch = '0;
      exp_frame = '0;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      check_all_zero("reset");
      rst = 1'b0;

      // din 1,0,1,1,0,0,1,0 on lanes 0..7
      send_frame(8'b0100_1101, 1'b0, 1'b0);
      check("frame1_const", 32'(frame_out), 32'h4D);

      // Back-to-back frames, no idle cycles
      send_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);

      // Early sync at cnt=3: partial frame abandoned, 0x3C must stay until the realigned frame ends
      lane(1'b1, 1'b1, 0, 1'b0);
      lane(1'b0, 1'b1, 1, 1'b0);
      lane(1'b0, 1'b0, 2, 1'b0);
      send_frame(8'h96, 1'b1, 1'b0);

      // Missing sync at cnt=0: lose lock, drop until next sync
      drop(1'b1, 1'b1);
      drop(1'b0, 1'b0);
      drop(1'b1, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b0);

      // Idle cycles between every accept
      send_frame(8'hC3, 1'b0, 1'b1);

      // Reset mid-frame at cnt=5, with a valid sync sample presented
      for (int i = 0; i < 5; i++) lane(i == 0, 1'b1, i, 1'b0);
      check("pre_rst_sel", 32'(ch_sel), 32'd5);
      rst = 1'b1;
      cycle(1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      exp_ch = '0;
      exp_frame = '0;
      check_all_zero("midrst");
      drop(1'b1, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0);

`ifdef TDM_DEMUX_ERR_CNT_EN
      // Repeated early syncs in LOCKED: each is an error, counter saturates
      rst = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      check("errcnt_rst", 32'(err_cnt), 32'd0);
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 300; k++) begin
         cycle(1'b1, 1'b1, 1'b0);
         if (k == 1) check("errcnt_2", 32'(err_cnt), 32'd2);
      end
      check("errcnt_sat", 32'(err_cnt), 32'd255);
      check("errcnt_pulse", 32'(sync_err), 32'd1);
      cycle(1'b0, 1'b0, 1'b0);
      check("errcnt_hold", 32'(err_cnt), 32'd255);
      check("errcnt_nopulse", 32'(sync_err), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
